// File: rtl/data_mem_pkg.sv
// Shared types and default sizes for the parametrised data memory.
package data_mem_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned AW_DEF = 8;

  typedef enum logic {CLEAR, READY} mem_state_t;

endpackage

// File: rtl/data_mem_param_if.sv
// Request/response bundle between the datapath and the data memory.
interface data_mem_param_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
);
  logic [AW-1:0] DataAddress;
  logic          ReadMem;
  logic          WriteMem;
  logic [DW-1:0] DataIn;
  logic [DW-1:0] DataOut;
  logic          DataValid;
  logic          Busy;

  modport master (
    output DataAddress, ReadMem, WriteMem, DataIn,
    input  DataOut, DataValid, Busy
  );

  modport slave (
    input  DataAddress, ReadMem, WriteMem, DataIn,
    output DataOut, DataValid, Busy
  );
endinterface

// File: rtl/mem_clear_seq.sv
// Post-reset zeroing sweep: walks every word once, then parks in READY.
module mem_clear_seq
  import data_mem_pkg::*;
#(
  parameter int unsigned AW             = AW_DEF,
  parameter int unsigned DEPTH          = 2**AW,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic          CLK,
  input  logic          reset,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          busy_o
);

  // One extra bit so DEPTH == 2**AW never wraps before the last compare.
  localparam logic [AW:0] LastIdx = (AW+1)'(DEPTH - 1);
  localparam mem_state_t  RstState = CLEAR_ON_RESET ? CLEAR : READY;

  mem_state_t    state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;

  // State and sweep counter registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= RstState;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: advance through the array, leave CLEAR after the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (cnt_q == LastIdx) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: state_d = READY;
      default: state_d = RstState;
    endcase
  end

  // Outputs: sweep write strobe, address and busy flag.
  always_comb begin
    busy_o     = (state_q == CLEAR);
    clr_we_o   = (state_q == CLEAR);
    clr_addr_o = cnt_q[AW-1:0];
  end

endmodule

// File: rtl/data_mem_param.sv
// Parametrised data memory: registered read, write-first bypass, post-reset clear sweep.
module data_mem_param
  import data_mem_pkg::*;
#(
  parameter int unsigned DW             = DW_DEF,
  parameter int unsigned AW             = AW_DEF,
  parameter int unsigned DEPTH          = 2**AW,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic             CLK,
  input  logic             reset,
  data_mem_param_if.slave  bus
);

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          in_range;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;

  mem_clear_seq #(
    .AW             (AW),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .CLK        (CLK),
    .reset      (reset),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .busy_o     (busy)
  );

  // Single write port: the sweep owns it while busy, the bus otherwise.
  always_comb begin
    in_range = ({1'b0, bus.DataAddress} < DepthW);
    if (busy) begin
      we    = clr_we;
      waddr = clr_addr;
      wdata = '0;
    end else begin
      we    = bus.WriteMem && in_range;
      waddr = bus.DataAddress;
      wdata = bus.DataIn;
    end
  end

  // Array write; contents deliberately have no reset.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register next state: write-first bypass, zero for out-of-range, hold when idle.
  always_comb begin
    dout_d  = dout_q;
    valid_d = 1'b0;
    if (busy) begin
      dout_d = '0;
    end else if (bus.ReadMem) begin
      valid_d = 1'b1;
      if (!in_range) begin
        dout_d = '0;
      end else if (bus.WriteMem) begin
        dout_d = bus.DataIn;
      end else begin
        dout_d = mem[bus.DataAddress];
      end
    end
  end

  // Read data and valid registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  // Drive the bus outputs.
  always_comb begin
    bus.DataOut   = dout_q;
    bus.DataValid = valid_q;
    bus.Busy      = busy;
  end

endmodule

// File: tb/tb_data_mem_param.sv
// Directed bench: full-depth instance (a) and a DEPTH=200 instance (b).
module tb_data_mem_param;

  logic CLK;
  logic rst_a;
  logic rst_b;

  int n_checks;
  int n_fail;

  data_mem_param_if #(.DW(8), .AW(8)) bus_a ();
  data_mem_param_if #(.DW(8), .AW(8)) bus_b ();

  data_mem_param #(.DW(8), .AW(8), .DEPTH(256), .CLEAR_ON_RESET(1'b1)) u_dut_a (
    .CLK   (CLK),
    .reset (rst_a),
    .bus   (bus_a.slave)
  );

  data_mem_param #(.DW(8), .AW(8), .DEPTH(200), .CLEAR_ON_RESET(1'b1)) u_dut_b (
    .CLK   (CLK),
    .reset (rst_b),
    .bus   (bus_b.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count cycles Busy stays high; starts right after a reset release between edges.
  task automatic count_busy(input bit sel, output int cycles);
    cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge CLK);
      cycles++;
      #1;
      if (!(sel ? bus_b.Busy : bus_a.Busy)) break;
    end
  endtask

  // Idle drivers; call at #1 after an edge.
  task automatic idle_a();
    bus_a.ReadMem  = 1'b0;
    bus_a.WriteMem = 1'b0;
  endtask

  task automatic write_a(input logic [7:0] addr, input logic [7:0] data);
    bus_a.DataAddress = addr;
    bus_a.DataIn      = data;
    bus_a.WriteMem    = 1'b1;
    bus_a.ReadMem     = 1'b0;
    @(posedge CLK); #1;
    idle_a();
  endtask

  task automatic read_a(input logic [7:0] addr, input logic [7:0] exp, input string name);
    bus_a.DataAddress = addr;
    bus_a.ReadMem     = 1'b1;
    bus_a.WriteMem    = 1'b0;
    @(posedge CLK); #1;
    idle_a();
    n_checks++;
    if (bus_a.DataValid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s valid: got %b expected 1", name, bus_a.DataValid);
    end
    n_checks++;
    if (bus_a.DataOut !== exp) begin
      n_fail++;
      $display("FAIL %s data: got %h expected %h", name, bus_a.DataOut, exp);
    end
  endtask

  task automatic test_reset();
    int cyc;
    rst_a = 1'b0;
    idle_a();
    bus_a.DataAddress = '0;
    bus_a.DataIn      = '0;
    #1;
    n_checks++;
    if (bus_a.Busy !== 1'b1 || bus_a.DataValid !== 1'b0 || bus_a.DataOut !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b valid=%b out=%h expected 1 0 00",
               bus_a.Busy, bus_a.DataValid, bus_a.DataOut);
    end
    @(negedge CLK);
    rst_a = 1'b1;
    count_busy(1'b0, cyc);
    n_checks++;
    if (cyc != 256) begin
      n_fail++;
      $display("FAIL sweep_length: got %0d cycles expected 256", cyc);
    end
    read_a(8'd0,   8'h00, "clear_rd0");
    read_a(8'd15,  8'h00, "clear_rd15");
    read_a(8'd255, 8'h00, "clear_rd255");
  endtask

  task automatic test_write_read();
    write_a(8'd15, 8'd3);
    write_a(8'd32, 8'd7);
    read_a(8'd32, 8'd7, "rd32");
    read_a(8'd15, 8'd3, "rd15");
    // No read: valid drops, data holds.
    @(posedge CLK); #1;
    n_checks++;
    if (bus_a.DataValid !== 1'b0 || bus_a.DataOut !== 8'd3) begin
      n_fail++;
      $display("FAIL idle_hold: valid=%b out=%h expected 0 03", bus_a.DataValid, bus_a.DataOut);
    end
  endtask

  task automatic test_write_first();
    bus_a.DataAddress = 8'd15;
    bus_a.DataIn      = 8'hA5;
    bus_a.ReadMem     = 1'b1;
    bus_a.WriteMem    = 1'b1;
    @(posedge CLK); #1;
    idle_a();
    n_checks++;
    if (bus_a.DataValid !== 1'b1 || bus_a.DataOut !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_first: valid=%b out=%h expected 1 a5", bus_a.DataValid, bus_a.DataOut);
    end
    read_a(8'd15, 8'hA5, "rd_after_wr");
  endtask

  // Requests during the sweep, issued after address 40 is already cleared.
  task automatic test_busy_ignore();
    int cyc;
    @(negedge CLK);
    rst_a = 1'b0;
    @(negedge CLK);
    rst_a = 1'b1;
    for (int i = 0; i < 100; i++) @(posedge CLK);
    #1;
    bus_a.DataAddress = 8'd40;
    bus_a.DataIn      = 8'h55;
    bus_a.ReadMem     = 1'b1;
    bus_a.WriteMem    = 1'b1;
    @(posedge CLK); #1;
    idle_a();
    n_checks++;
    if (bus_a.DataValid !== 1'b0 || bus_a.DataOut !== 8'h00 || bus_a.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_ignore: valid=%b out=%h busy=%b expected 0 00 1",
               bus_a.DataValid, bus_a.DataOut, bus_a.Busy);
    end
    count_busy(1'b0, cyc);
    read_a(8'd40, 8'h00, "rd40_after_sweep");
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    write_a(8'd200, 8'h3C);
    read_a(8'd200, 8'h3C, "rd200_preset");
    @(negedge CLK);
    rst_a = 1'b0;
    @(negedge CLK);
    rst_a = 1'b1;
    for (int i = 0; i < 100; i++) @(posedge CLK);
    #1;
    rst_a = 1'b0;
    #1;
    n_checks++;
    if (bus_a.Busy !== 1'b1 || bus_a.DataValid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: busy=%b valid=%b expected 1 0", bus_a.Busy, bus_a.DataValid);
    end
    @(negedge CLK);
    rst_a = 1'b1;
    count_busy(1'b0, cyc);
    n_checks++;
    if (cyc != 256) begin
      n_fail++;
      $display("FAIL midreset_sweep_length: got %0d cycles expected 256", cyc);
    end
    read_a(8'd200, 8'h00, "rd200_after_resweep");
  endtask

  task automatic test_out_of_range();
    int cyc;
    rst_b = 1'b0;
    bus_b.ReadMem     = 1'b0;
    bus_b.WriteMem    = 1'b0;
    bus_b.DataAddress = '0;
    bus_b.DataIn      = '0;
    @(negedge CLK);
    rst_b = 1'b1;
    count_busy(1'b1, cyc);
    n_checks++;
    if (cyc != 200) begin
      n_fail++;
      $display("FAIL b_sweep_length: got %0d cycles expected 200", cyc);
    end
    // Write 9 to 220 (dropped), then read it back.
    bus_b.DataAddress = 8'd220;
    bus_b.DataIn      = 8'd9;
    bus_b.WriteMem    = 1'b1;
    @(posedge CLK); #1;
    bus_b.WriteMem    = 1'b0;
    bus_b.ReadMem     = 1'b1;
    @(posedge CLK); #1;
    bus_b.ReadMem     = 1'b0;
    n_checks++;
    if (bus_b.DataValid !== 1'b1 || bus_b.DataOut !== 8'h00) begin
      n_fail++;
      $display("FAIL oor_read: valid=%b out=%h expected 1 00", bus_b.DataValid, bus_b.DataOut);
    end
    // Last in-range word.
    bus_b.DataAddress = 8'd199;
    bus_b.WriteMem    = 1'b1;
    @(posedge CLK); #1;
    bus_b.WriteMem    = 1'b0;
    bus_b.ReadMem     = 1'b1;
    @(posedge CLK); #1;
    bus_b.ReadMem     = 1'b0;
    n_checks++;
    if (bus_b.DataValid !== 1'b1 || bus_b.DataOut !== 8'd9) begin
      n_fail++;
      $display("FAIL last_word_read: valid=%b out=%h expected 1 09",
               bus_b.DataValid, bus_b.DataOut);
    end
    // Out-of-range read with write in the same cycle still returns 0.
    bus_b.DataAddress = 8'd250;
    bus_b.DataIn      = 8'h77;
    bus_b.WriteMem    = 1'b1;
    bus_b.ReadMem     = 1'b1;
    @(posedge CLK); #1;
    bus_b.WriteMem    = 1'b0;
    bus_b.ReadMem     = 1'b0;
    n_checks++;
    if (bus_b.DataValid !== 1'b1 || bus_b.DataOut !== 8'h00) begin
      n_fail++;
      $display("FAIL oor_rw: valid=%b out=%h expected 1 00", bus_b.DataValid, bus_b.DataOut);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_b    = 1'b0;
    test_reset();
    test_write_read();
    test_write_first();
    test_busy_ignore();
    test_reset_mid_sweep();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
